// File: rtl/rom_stream_reader.sv
// Burst reader in front of a 1-cycle-latency synchronous ROM.
// Ports: start/base/len request; rom_addr/rom_data; m_* stream; busy/done.
module rom_stream_reader #(
  parameter int DATA = 8,
  parameter int ADDR = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [ADDR-1:0] base,
  input  logic [ADDR:0]   len,
  output logic [ADDR-1:0] rom_addr,
  input  logic [DATA-1:0] rom_data,
  output logic [DATA-1:0] m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            busy,
  output logic            done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nx;

  logic [ADDR:0]   remaining;
  logic            inflight;
  logic [DATA-1:0] fifo [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      occ;
  logic            pop;
  logic            push;
  logic            issue;
  logic            launch;
  logic            zero_req;
  logic            last;

  assign pop     = m_valid & m_ready;
  assign push    = inflight;
  assign m_valid = (occ != 2'd0);
  assign m_data  = fifo[rd_ptr];
  assign busy    = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Issue only when the word will still fit once the
  // in-flight read lands, counting this cycle's pop.
  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    launch   = 1'b0;
    zero_req = 1'b0;
    last     = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (start) begin
          if (len != '0) begin
            launch   = 1'b1;
            state_nx = RUN;
          end else begin
            zero_req = 1'b1;
          end
        end
      end
      (state == RUN): begin
        issue = (remaining != '0) &&
                (({1'b0, occ} + {2'b0, inflight})
                 <= (3'd1 + {2'b0, pop}));
        last  = (remaining == '0) && (occ == 2'd1) &&
                pop && !inflight;
        if (last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr  <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      done      <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occ       <= 2'd0;
      fifo[0]   <= '0;
      fifo[1]   <= '0;
    end else begin
      done     <= zero_req | last;
      inflight <= issue;
      if (launch) begin
        rom_addr  <= base;
        remaining <= len;
      end else if (issue) begin
        rom_addr  <= rom_addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      if (push) begin
        fifo[wr_ptr] <= rom_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      assert (!(push && (occ == 2'd2) && !pop))
        else $error("fifo push while full");
  end

endmodule
